// File: rtl/round_const_mem.sv
// Round-constant table: DEPTH entries preset to the AES rcon sequence, with a
// regeneration FSM. Optional stored parity is enabled by ROUND_CONST_MEM_PARITY_EN.
module round_const_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err,
  input  logic              gen_start,
  output logic              busy,
  output logic              gen_done,
  output logic              par_err,
  output logic              dbg_state
);

  // Handshake: rd_en/wr_en are single-cycle requests sampled on the rising
  // edge while IDLE; every accepted read answers with a one-cycle rd_valid.
  typedef enum logic {ST_IDLE = 1'b0, ST_GEN = 1'b1} state_e;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  function automatic logic [DATA_W-1:0] rcon(input int idx);
    logic [7:0] c;
    c = 8'h01;
    for (int k = 1; k < 16; k++) begin
      if (k <= idx) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1B : 8'h00);
    end
    return DATA_W'(c);
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] gen_idx_q, gen_idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              gen_done_q, gen_done_d;
  logic              wr_ok, rd_ok;

  assign wr_ok = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH_L);

`ifdef ROUND_CONST_MEM_PARITY_EN
  logic par_q [DEPTH];
  logic par_d [DEPTH];
  logic par_err_q, par_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    gen_idx_d  = gen_idx_q;
    mem_d      = mem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    gen_done_d = 1'b0;
`ifdef ROUND_CONST_MEM_PARITY_EN
    par_d      = par_q;
    par_err_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Read uses mem_q, so a same-address write in this cycle is not seen.
        if (wr_en) begin
          if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
`ifdef ROUND_CONST_MEM_PARITY_EN
            par_d[wr_addr] = ^wr_data;
`endif
          end else begin
            addr_err_d = 1'b1;
          end
        end
        if (rd_en) begin
          rd_valid_d = 1'b1;
          if (rd_ok) begin
            rd_data_d = mem_q[rd_addr];
`ifdef ROUND_CONST_MEM_PARITY_EN
            par_err_d = (^mem_q[rd_addr]) ^ par_q[rd_addr];
`endif
          end else begin
            rd_data_d  = '0;
            addr_err_d = 1'b1;
          end
        end
        if (gen_start) begin
          state_d   = ST_GEN;
          gen_idx_d = '0;
        end
      end
      ST_GEN: begin
        mem_d[gen_idx_q] = rcon(int'(gen_idx_q));
`ifdef ROUND_CONST_MEM_PARITY_EN
        par_d[gen_idx_q] = ^rcon(int'(gen_idx_q));
`endif
        if (gen_idx_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          gen_done_d = 1'b1;
        end else begin
          gen_idx_d = gen_idx_q + ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gen_idx_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      gen_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= rcon(i);
    end else begin
      state_q    <= state_d;
      gen_idx_q  <= gen_idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
      gen_done_q <= gen_done_d;
      mem_q      <= mem_d;
    end
  end

`ifdef ROUND_CONST_MEM_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) par_q[i] <= ^rcon(i);
    end else begin
      par_err_q <= par_err_d;
      par_q     <= par_d;
    end
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign addr_err  = addr_err_q;
  assign gen_done  = gen_done_q;
  assign busy      = (state_q == ST_GEN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_round_const_mem.sv
// Self-checking bench for round_const_mem (DATA_W=8, DEPTH=10, ADDR_W=4).
module tb_round_const_mem;

  localparam int DEPTH = 10;

  logic       clk, rst;
  logic       wr_en, rd_en, gen_start;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, addr_err, busy, gen_done, par_err, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m [16];
  logic [7:0] defs [DEPTH] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [7:0] exp_q [$];

  round_const_mem #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .addr_err(addr_err), .gen_start(gen_start), .busy(busy),
    .gen_done(gen_done), .par_err(par_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of requests, return 1 time unit after the rising edge.
  task automatic drive(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                       input logic r, input logic [3:0] ra, input logic g);
    wr_en = w; wr_addr = wa; wr_data = wd;
    rd_en = r; rd_addr = ra; gen_start = g;
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    for (int i = 0; i < 16; i++) m[i] = (i < DEPTH) ? defs[i] : 8'h00;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({rd_data, rd_valid, addr_err, busy, gen_done, par_err} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {rd_data, rd_valid, addr_err, busy, gen_done, par_err});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    drive(1, 4'd0, 8'hAA, 0, 4'd0, 0);
    drive(0, 4'd0, 8'h00, 1, 4'd0, 0);
    n_checks++;
    if (rd_data !== 8'hAA) begin
      n_fail++; $display("FAIL pre_reset_read: got %h required aa", rd_data);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rd_data, rd_valid, busy, gen_done} !== 11'h0) begin
      n_fail++; $display("FAIL async_reset: got rd_data=%h valid=%b busy=%b done=%b required 0",
                         rd_data, rd_valid, busy, gen_done);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    set_defaults();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 4'd0, 8'h00, 1, 4'(i), 0);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== defs[i] || addr_err !== 1'b0) begin
        n_fail++; $display("FAIL default_read[%0d]: got valid=%b data=%h err=%b required 1 %h 0",
                           i, rd_valid, rd_data, addr_err, defs[i]);
      end
    end
    drive(0, 4'd0, 8'h00, 0, 4'd0, 0);
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h36) begin
      n_fail++; $display("FAIL rd_data_hold: got valid=%b data=%h required 0 36", rd_valid, rd_data);
    end
  endtask

  task automatic test_write_read();
    drive(1, 4'd3, 8'hAA, 0, 4'd0, 0);
    n_checks++;
    if (addr_err !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_flags: got err=%b valid=%b required 0 0", addr_err, rd_valid);
    end
    drive(0, 4'd0, 8'h00, 1, 4'd3, 0);
    n_checks++;
    if (rd_data !== 8'hAA) begin
      n_fail++; $display("FAIL write_then_read: got %h required aa", rd_data);
    end
    drive(1, 4'd3, 8'h55, 1, 4'd3, 0);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hAA) begin
      n_fail++; $display("FAIL same_cycle_old: got valid=%b data=%h required 1 aa", rd_valid, rd_data);
    end
    drive(0, 4'd0, 8'h00, 1, 4'd3, 0);
    n_checks++;
    if (rd_data !== 8'h55) begin
      n_fail++; $display("FAIL same_cycle_new: got %h required 55", rd_data);
    end
    m[3] = 8'h55;
  endtask

  task automatic test_addr_err();
    drive(0, 4'd0, 8'h00, 1, 4'd12, 0);
    n_checks++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b1 || addr_err !== 1'b1) begin
      n_fail++; $display("FAIL oob_read: got data=%h valid=%b err=%b required 00 1 1",
                         rd_data, rd_valid, addr_err);
    end
    drive(1, 4'd12, 8'hFF, 0, 4'd0, 0);
    n_checks++;
    if (addr_err !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL oob_write: got err=%b valid=%b required 1 0", addr_err, rd_valid);
    end
    drive(0, 4'd0, 8'h00, 0, 4'd0, 0);
    n_checks++;
    if (addr_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse_width: got %b required 0", addr_err);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 4'd0, 8'h00, 1, 4'(i), 0);
      n_checks++;
      if (rd_data !== m[i] || addr_err !== 1'b0) begin
        n_fail++; $display("FAIL table_after_oob[%0d]: got %h err=%b required %h 0",
                           i, rd_data, addr_err, m[i]);
      end
    end
  endtask

  task automatic test_random();
    logic       w, r, exp_err;
    logic [3:0] wa, ra;
    logic [7:0] wd, got;
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      wd = 8'($urandom);
      exp_err = (w && wa >= DEPTH) || (r && ra >= DEPTH);
      if (r) exp_q.push_back((ra < DEPTH) ? m[ra] : 8'h00);
      if (w && wa < DEPTH) m[wa] = wd;
      drive(w, wa, wd, r, ra, 0);
      n_checks++;
      if (rd_valid !== r || addr_err !== exp_err || par_err !== 1'b0) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got valid=%b err=%b par=%b required %b %b 0",
                           n, rd_valid, addr_err, par_err, r, exp_err);
      end
      if (rd_valid === 1'b1 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_checks++;
        if (rd_data !== got) begin
          n_fail++; $display("FAIL rand_data[%0d]: got %h required %h", n, rd_data, got);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_gen();
    drive(1, 4'd0, 8'h5A, 0, 4'd0, 0);
    drive(1, 4'd4, 8'hC3, 0, 4'd0, 0);
    drive(1, 4'd9, 8'h00, 0, 4'd0, 0);
    drive(0, 4'd0, 8'h00, 0, 4'd0, 1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL gen_enter: got busy=%b required 1", busy);
    end
    for (int c = 1; c <= DEPTH; c++) begin
      drive(1, 4'd3, 8'hEE, 1, 4'(c), 1);
      n_checks++;
      if (busy !== (c < DEPTH) || gen_done !== (c == DEPTH) ||
          rd_valid !== 1'b0 || addr_err !== 1'b0) begin
        n_fail++; $display("FAIL gen_cycle[%0d]: got busy=%b done=%b valid=%b err=%b required %b %b 0 0",
                           c, busy, gen_done, rd_valid, addr_err, c < DEPTH, c == DEPTH);
      end
    end
    drive(0, 4'd0, 8'h00, 0, 4'd0, 0);
    n_checks++;
    if (gen_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL gen_done_pulse: got done=%b busy=%b required 0 0", gen_done, busy);
    end
    set_defaults();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 4'd0, 8'h00, 1, 4'(i), 0);
      n_checks++;
      if (rd_data !== m[i]) begin
        n_fail++; $display("FAIL table_after_gen[%0d]: got %h required %h", i, rd_data, m[i]);
      end
    end
  endtask

  task automatic test_combo();
    drive(1, 4'd5, 8'h77, 1, 4'd5, 1);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== m[5] || busy !== 1'b1) begin
      n_fail++; $display("FAIL combo_start: got valid=%b data=%h busy=%b required 1 %h 1",
                         rd_valid, rd_data, busy, m[5]);
    end
    for (int c = 1; c <= DEPTH; c++) drive(0, 4'd0, 8'h00, 0, 4'd0, 0);
    n_checks++;
    if (gen_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL combo_done: got done=%b busy=%b required 1 0", gen_done, busy);
    end
    set_defaults();
  endtask

  task automatic test_rst_mid_gen();
    drive(1, 4'd7, 8'h99, 0, 4'd0, 0);
    drive(0, 4'd0, 8'h00, 0, 4'd0, 1);
    for (int c = 0; c < 3; c++) drive(0, 4'd0, 8'h00, 0, 4'd0, 0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || gen_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_gen: got busy=%b done=%b required 0 0", busy, gen_done);
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(0, 4'd0, 8'h00, 0, 4'd0, 0);
      n_checks++;
      if (gen_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rst_no_done[%0d]: got done=%b busy=%b required 0 0", c, gen_done, busy);
      end
    end
    set_defaults();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 4'd0, 8'h00, 1, 4'(i), 0);
      n_checks++;
      if (rd_data !== m[i] || par_err !== 1'b0) begin
        n_fail++; $display("FAIL table_after_rst[%0d]: got %h par=%b required %h 0",
                           i, rd_data, par_err, m[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; gen_start = 1'b0;
    set_defaults();
    test_reset();
    test_write_read();
    test_addr_err();
    test_random();
    test_gen();
    test_combo();
    test_rst_mid_gen();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
